// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution datapath.
//   DATA_W   - bits per pixel/kernel element
//   MAX_N    - largest supported matrix dimension
//   VEC_W    - width of a packed 5-column window vector
//   SIZE_*   - matrix_size encodings (N = code + 2)
//   state_t  - loader FSM states
//   idx()    - linear slot of element (r,c) in the 5-column layout
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int MAX_N  = 5;
    localparam int VEC_W  = MAX_N * MAX_N * DATA_W;

    localparam logic [1:0] SIZE_2X2 = 2'b00;
    localparam logic [1:0] SIZE_3X3 = 2'b01;
    localparam logic [1:0] SIZE_4X4 = 2'b10;
    localparam logic [1:0] SIZE_5X5 = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_K = 2'd1,
        LOAD_P = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The layout always uses a stride of 5 columns, whatever N is, so the
    // convolution stage can address elements without knowing the size.
    function automatic logic [4:0] idx(input logic [2:0] r, input logic [2:0] c);
        return ({2'b00, r} * 5'd5) + {2'b00, c};
    endfunction

endpackage

// File: rtl/conv_rc_counter.sv
// conv_rc_counter: row/column walker over an N x N window, row-major.
//   clk, rst_n  - clock, asynchronous active-low reset
//   n_i         - current matrix dimension (2..5)
//   adv_i       - advance one element
//   clr_i       - force back to (0,0); wins over adv_i
//   row_o/col_o - current element position
//   last_o      - current position is (N-1, N-1)
module conv_rc_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] n_i,
    input  logic       adv_i,
    input  logic       clr_i,
    output logic [2:0] row_o,
    output logic [2:0] col_o,
    output logic       last_o
);

    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic       col_end;

    assign col_end = (col_q == n_i - 3'd1);
    assign last_o  = col_end && (row_q == n_i - 3'd1);
    assign row_o   = row_q;
    assign col_o   = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (adv_i) begin
            if (last_o) begin
                // wrap so the next load phase starts at (0,0)
                row_d = '0;
                col_d = '0;
            end else if (col_end) begin
                row_d = row_q + 3'd1;
                col_d = '0;
            end else begin
                col_d = col_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/conv_window_loader.sv
// conv_window_loader: packs a row-major byte stream (kernel then pixels)
// into 5-column linear vectors for the convolution stage.
//   clk, rst_n              - clock, asynchronous active-low reset
//   start, matrix_size,
//   reuse_kernel            - load request, sampled in IDLE only
//   in_data/in_valid/in_ready - input byte stream handshake
//   pixel_out/kernel_out/size_out/out_valid/out_ready - packed window handshake
//   busy                    - loader not idle
module conv_window_loader
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        matrix_size,
    input  logic              reuse_kernel,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [VEC_W-1:0]  pixel_out,
    output logic [VEC_W-1:0]  kernel_out,
    output logic [1:0]        size_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    state_t             state_q, state_d;
    logic [1:0]         size_q, size_d;
    logic [VEC_W-1:0]   kern_q, kern_d;
    logic [VEC_W-1:0]   pix_q, pix_d;

    logic [2:0]         n;
    logic [2:0]         row, col;
    logic               last;
    logic               beat;
    logic               cnt_clr;
    logic [7:0]         bit_base;

    assign n        = {1'b0, size_q} + 3'd2;
    assign in_ready = (state_q == LOAD_K) || (state_q == LOAD_P);
    assign beat     = in_valid && in_ready;
    assign bit_base = {idx(row, col), 3'b000};

    // One counter serves both load phases; it wraps to (0,0) on the last
    // kernel beat, so the pixel phase starts clean without an extra clear.
    conv_rc_counter u_rc (
        .clk    (clk),
        .rst_n  (rst_n),
        .n_i    (n),
        .adv_i  (beat),
        .clr_i  (cnt_clr),
        .row_o  (row),
        .col_o  (col),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        kern_d  = kern_q;
        pix_d   = pix_q;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_clr = 1'b1;
                    // Whole-vector clears keep slots outside the new N x N
                    // window at zero after a larger previous window.
                    pix_d   = '0;
                    if (reuse_kernel) begin
                        state_d = LOAD_P;
                    end else begin
                        size_d  = matrix_size;
                        kern_d  = '0;
                        state_d = LOAD_K;
                    end
                end
            end
            LOAD_K: begin
                if (beat) begin
                    kern_d[bit_base +: DATA_W] = in_data;
                    if (last) state_d = LOAD_P;
                end
            end
            LOAD_P: begin
                if (beat) begin
                    pix_d[bit_base +: DATA_W] = in_data;
                    if (last) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            size_q  <= SIZE_2X2;
            kern_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            kern_q  <= kern_d;
            pix_q   <= pix_d;
        end
    end

    assign pixel_out  = pix_q;
    assign kernel_out = kern_q;
    assign size_out   = size_q;
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_conv_window_loader.sv
// Testbench for conv_window_loader: directed scenarios plus randomized loads,
// checked against an element-array model of the expected window.
module tb_conv_window_loader;

    typedef logic [7:0] bq_t[$];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   matrix_size = 2'b00;
    logic         reuse_kernel = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [199:0] pixel_out;
    logic [199:0] kernel_out;
    logic [1:0]   size_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: element values by slot r*5+c, plus stored size.
    logic [7:0] m_k[25];
    logic [7:0] m_p[25];
    logic [1:0] m_size;

    conv_window_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .matrix_size  (matrix_size),
        .reuse_kernel (reuse_kernel),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pixel_out    (pixel_out),
        .kernel_out   (kernel_out),
        .size_out     (size_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [199:0] pack(input logic [7:0] a[25]);
        logic [199:0] v;
        v = '0;
        for (int s = 0; s < 25; s++) v[s*8 +: 8] = a[s];
        return v;
    endfunction

    function automatic bq_t mkq(input int base, input int step, input bit rnd);
        bq_t q;
        for (int i = 0; i < 25; i++)
            q.push_back(rnd ? 8'($urandom) : 8'(base + step * i));
        return q;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 25; s++) begin
            m_k[s] = 8'h00;
            m_p[s] = 8'h00;
        end
        m_size = 2'b00;
    endtask

    // Issue start, stream bytes (gap=1: valid only every other cycle) until
    // out_valid, then compare the presented window with the model.
    task automatic run_load(input logic [1:0] sz, input logic rs, input bq_t kq,
                            input bq_t pq, input bit gap, input string name);
        int n, beats, cyc;
        logic rdy, v;
        bq_t stream;
        if (!rs) begin
            m_size = sz;
            for (int s = 0; s < 25; s++) m_k[s] = 8'h00;
        end
        for (int s = 0; s < 25; s++) m_p[s] = 8'h00;
        n = int'(m_size) + 2;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                if (!rs) m_k[r*5+c] = kq[r*n+c];
                m_p[r*5+c] = pq[r*n+c];
            end
        if (!rs) for (int i = 0; i < n*n; i++) stream.push_back(kq[i]);
        for (int i = 0; i < n*n; i++) stream.push_back(pq[i]);

        start = 1'b1; matrix_size = sz; reuse_kernel = rs;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy after start: got %b want 1", name, busy);
        end
        beats = 0; cyc = 0;
        while (out_valid !== 1'b1 && cyc < 400) begin
            in_valid = gap ? ((cyc % 2) == 0) : 1'b1;
            in_data  = (beats < stream.size()) ? stream[beats] : 8'hEE;
            rdy = in_ready; v = in_valid;
            @(posedge clk); #1;
            if (v && rdy) beats++;
            cyc++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (beats != stream.size() || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s beats: got %0d (out_valid=%b) want %0d", name, beats, out_valid, stream.size());
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s in_ready in DONE: got %b want 0", name, in_ready);
        end
        n_checks++;
        if (size_out !== m_size) begin
            n_fail++; $display("FAIL %s size_out: got %b want %b", name, size_out, m_size);
        end
        n_checks++;
        if (kernel_out !== pack(m_k)) begin
            n_fail++; $display("FAIL %s kernel_out: got %h want %h", name, kernel_out, pack(m_k));
        end
        n_checks++;
        if (pixel_out !== pack(m_p)) begin
            n_fail++; $display("FAIL %s pixel_out: got %h want %h", name, pixel_out, pack(m_p));
        end
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s after handshake: got busy=%b out_valid=%b want 0 0", name, busy, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pixel_out !== '0 || kernel_out !== '0 || size_out !== 2'b00 ||
            out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset values: got pix=%h ker=%h size=%b ov=%b ir=%b busy=%b want all 0",
                     pixel_out, kernel_out, size_out, out_valid, in_ready, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL idle after reset: got busy=%b in_ready=%b want 0 0", busy, in_ready);
        end
    endtask

    task automatic test_full_load_3x3();
        run_load(2'b01, 1'b0, mkq(1, 1, 0), mkq(10, 10, 0), 1'b0, "load3x3");
        n_checks++;
        if (pixel_out[12*8 +: 8] !== 8'd90 || kernel_out[12*8 +: 8] !== 8'h09) begin
            n_fail++; $display("FAIL load3x3 slot12: got pix=%h ker=%h want 5a 09",
                               pixel_out[12*8 +: 8], kernel_out[12*8 +: 8]);
        end
        handshake("load3x3");
    endtask

    task automatic test_backpressure();
        run_load(2'b00, 1'b0, mkq(8'h30, 1, 0), mkq(8'h40, 3, 0), 1'b1, "bp2x2");
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2) == 0;
            in_data  = 8'h77;
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || pixel_out !== pack(m_p) || kernel_out !== pack(m_k) || size_out !== m_size) begin
                n_fail++; $display("FAIL bp hold cycle %0d: got ov=%b pix=%h want ov=1 pix=%h",
                                   i, out_valid, pixel_out, pack(m_p));
            end
        end
        in_valid = 1'b0;
        handshake("bp2x2");
    endtask

    task automatic test_reuse_resize();
        run_load(2'b11, 1'b0, mkq(8'hFF, 0, 0), mkq(0, 0, 1), 1'b0, "load5x5");
        handshake("load5x5");
        // reuse with a different requested size: stored size 5x5 must win
        run_load(2'b00, 1'b1, mkq(0, 0, 1), mkq(0, 0, 1), 1'b0, "reuse5x5");
        handshake("reuse5x5");
    endtask

    task automatic test_stale_clear();
        run_load(2'b11, 1'b0, mkq(0, 0, 1), mkq(8'hAA, 0, 0), 1'b0, "stale5x5");
        handshake("stale5x5");
        run_load(2'b00, 1'b0, mkq(0, 0, 1), mkq(1, 0, 0), 1'b0, "stale2x2");
        handshake("stale2x2");
    endtask

    task automatic test_midload_reset();
        start = 1'b1; matrix_size = 2'b01; reuse_kernel = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h51 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (pixel_out !== '0 || kernel_out !== '0 || size_out !== 2'b00 ||
            out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midload async reset: got ker=%h ir=%b busy=%b want all 0", kernel_out, in_ready, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        // no kernel loaded since reset: reuse uses a zero kernel of size 2x2
        run_load(2'b11, 1'b1, mkq(0, 0, 1), mkq(0, 0, 1), 1'b0, "reuse_after_rst");
        handshake("reuse_after_rst");
        run_load(2'b00, 1'b0, mkq(0, 0, 1), mkq(0, 0, 1), 1'b0, "after_rst2x2");
        handshake("after_rst2x2");
    endtask

    task automatic test_start_ignored();
        int beats;
        logic rdy;
        model_reset_size_keep();
        // start stays high with a different size through both load phases
        m_size = 2'b00;
        for (int s = 0; s < 25; s++) begin m_k[s] = 8'h00; m_p[s] = 8'h00; end
        start = 1'b1; matrix_size = 2'b00; reuse_kernel = 1'b0;
        @(posedge clk); #1;
        matrix_size = 2'b11; reuse_kernel = 1'b1;
        beats = 0;
        for (int i = 0; i < 40 && out_valid !== 1'b1; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hC0 + beats);
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                if (beats < 4) m_k[(beats/2)*5 + beats%2] = 8'(8'hC0 + beats);
                else if (beats < 8) m_p[((beats-4)/2)*5 + (beats-4)%2] = 8'(8'hC0 + beats);
                beats++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (beats != 8 || size_out !== 2'b00 || pixel_out !== pack(m_p) || kernel_out !== pack(m_k)) begin
            n_fail++; $display("FAIL start_ignored load: got beats=%0d size=%b pix=%h want 8 00 %h",
                               beats, size_out, pixel_out, pack(m_p));
        end
        // start coincident with the output handshake
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL start_ignored handshake: got busy=%b ov=%b want 0 0", busy, out_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL start_ignored idle: got busy=%b ir=%b want 0 0", busy, in_ready);
        end
    endtask

    task automatic model_reset_size_keep();
        reuse_kernel = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] sz;
        logic rs;
        bit gap;
        for (int it = 0; it < 8; it++) begin
            sz  = 2'($urandom_range(0, 3));
            rs  = 1'($urandom_range(0, 1));
            gap = 1'($urandom_range(0, 1));
            run_load(sz, rs, mkq(0, 0, 1), mkq(0, 0, 1), gap, "random");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            handshake("random");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_load_3x3();
        test_backpressure();
        test_reuse_resize();
        test_stale_clear();
        test_midload_reset();
        test_start_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
